// File: rtl/ram_ctrl_pkg.sv
// Shared types and default geometry for the matrix RAM read/write controllers.
// Optional build macro RAM_WR_PARITY_EN appends an even-parity bit to each written word.
package ram_ctrl_pkg;

  localparam int DEF_DATA_W = 1024;
  localparam int DEF_WORD_W = 32;
  localparam int DEF_ROWS   = 32;
  localparam int DEF_ADDR_W = 10;
  localparam int WPR        = DEF_DATA_W / DEF_WORD_W;

`ifdef RAM_WR_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/ram_write_controller_if.sv
// Row-accept handshake plus RAM write port of the write-back controller.
interface ram_write_controller_if
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int WORD_W = DEF_WORD_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic                    row_valid;
  logic [DATA_W-1:0]       row_data;
  logic                    row_ready;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [WORD_W+PAR_W-1:0] wr_data;

  modport master (
    input  row_valid, row_data,
    output row_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output row_valid, row_data,
    input  row_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/ram_wr_serializer.sv
// Holds one result row and presents it one WORD_W slice at a time, low word first.
// With RAM_WR_PARITY_EN the presented word carries an even-parity bit on top.
module ram_wr_serializer
  import ram_ctrl_pkg::*;
#(
  parameter  int DATA_W  = DEF_DATA_W,
  parameter  int WORD_W  = DEF_WORD_W,
  localparam int N_WORDS = DATA_W / WORD_W,
  localparam int CNT_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic                    shift,
  input  logic [DATA_W-1:0]       row_data,
  output logic [CNT_W-1:0]        word_cnt,
  output logic                    last,
  output logic [WORD_W+PAR_W-1:0] word
);

  logic [DATA_W-1:0] shift_r;
  logic [CNT_W-1:0]  word_cnt_r;

`ifdef RAM_WR_PARITY_EN
  function automatic logic even_parity(input logic [WORD_W-1:0] value);
    return ^value;
  endfunction
`endif

  // Row shift register and word index; a load always restarts at word 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r    <= {DATA_W{1'b0}};
      word_cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      shift_r    <= row_data;
      word_cnt_r <= {CNT_W{1'b0}};
    end else if (shift) begin
      shift_r    <= shift_r >> WORD_W;
      word_cnt_r <= word_cnt_r + CNT_W'(1);
    end
  end

  assign word_cnt = word_cnt_r;
  assign last     = (word_cnt_r == CNT_W'(N_WORDS - 1));

`ifdef RAM_WR_PARITY_EN
  assign word = {even_parity(shift_r[WORD_W-1:0]), shift_r[WORD_W-1:0]};
`else
  assign word = shift_r[WORD_W-1:0];
`endif

endmodule

// File: rtl/ram_write_controller.sv
// Writes ROWS result rows to RAM as consecutive words starting at BASE_ADDR, then pulses finish.
// Build macro RAM_WR_PARITY_EN widens wr_data by one even-parity bit.
module ram_write_controller
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int WORD_W    = DEF_WORD_W,
  parameter int ROWS      = DEF_ROWS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int BASE_ADDR = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   finish,
  ram_write_controller_if.master bus
);

  localparam int N_WORDS = DATA_W / WORD_W;
  localparam int CNT_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_e                  state_r;
  state_e                  next_state_s;
  logic [ROW_W-1:0]        row_cnt_r;
  logic                    load_s;
  logic                    shift_s;
  logic                    row_clr_s;
  logic                    row_inc_s;
  logic [CNT_W-1:0]        word_cnt_s;
  logic                    last_s;
  logic [WORD_W+PAR_W-1:0] word_s;
  logic [ADDR_W-1:0]       row_base_s;
  logic [ADDR_W-1:0]       addr_s;
  logic                    writing_s;

  ram_wr_serializer #(
    .DATA_W (DATA_W),
    .WORD_W (WORD_W)
  ) u_serializer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_s),
    .shift    (shift_s),
    .row_data (bus.row_data),
    .word_cnt (word_cnt_s),
    .last     (last_s),
    .word     (word_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode and serializer/row-counter controls.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    shift_s      = 1'b0;
    row_clr_s    = 1'b0;
    row_inc_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = LOAD;
          row_clr_s    = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      LOAD: begin
        if (bus.row_valid) begin
          load_s       = 1'b1;
          next_state_s = WRITE;
        end else begin
          next_state_s = LOAD;
        end
      end
      WRITE: begin
        shift_s = 1'b1;
        if (last_s) begin
          if (row_cnt_r == ROW_W'(ROWS - 1)) begin
            next_state_s = DONE;
          end else begin
            row_inc_s    = 1'b1;
            next_state_s = LOAD;
          end
        end else begin
          next_state_s = WRITE;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Row counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt_r <= {ROW_W{1'b0}};
    end else if (row_clr_s) begin
      row_cnt_r <= {ROW_W{1'b0}};
    end else if (row_inc_s) begin
      row_cnt_r <= row_cnt_r + ROW_W'(1);
    end
  end

  // Address arithmetic is done at ADDR_W so it wraps modulo the RAM size.
  assign row_base_s = ADDR_W'(32'(row_cnt_r) * 32'(N_WORDS));
  assign addr_s     = ADDR_W'(BASE_ADDR) + row_base_s + ADDR_W'(word_cnt_s);
  assign writing_s  = (state_r == WRITE);

  assign bus.row_ready = (state_r == LOAD);
  assign bus.wr_en     = writing_s;
  assign bus.wr_addr   = writing_s ? addr_s : {ADDR_W{1'b0}};
  assign bus.wr_data   = writing_s ? word_s : {(WORD_W+PAR_W){1'b0}};
  assign busy          = (state_r != IDLE);
  assign finish        = (state_r == DONE);

endmodule

// File: tb/tb_ram_write_controller.sv
// Scoreboard bench: two controllers (BASE_ADDR 0 and 1000) share one row producer.
module tb_ram_write_controller;
  import ram_ctrl_pkg::*;

  localparam int DATA_W = 1024;
  localparam int WORD_W = 32;
  localparam int ROWS   = 32;
  localparam int ADDR_W = 10;
  localparam int NW     = DATA_W / WORD_W;
  localparam int DW     = WORD_W + PAR_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy0, finish0, busy1, finish1;
  int   cyc   = 0;

  ram_write_controller_if #(.DATA_W(DATA_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus0 ();
  ram_write_controller_if #(.DATA_W(DATA_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus1 ();

  assign bus1.row_valid = bus0.row_valid;
  assign bus1.row_data  = bus0.row_data;

  ram_write_controller #(
    .DATA_W(DATA_W), .WORD_W(WORD_W), .ROWS(ROWS), .ADDR_W(ADDR_W), .BASE_ADDR(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy0), .finish(finish0), .bus(bus0.master)
  );

  ram_write_controller #(
    .DATA_W(DATA_W), .WORD_W(WORD_W), .ROWS(ROWS), .ADDR_W(ADDR_W), .BASE_ADDR(1000)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy1), .finish(finish1), .bus(bus1.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [ADDR_W-1:0] a0;
    logic [ADDR_W-1:0] a1;
    logic [DW-1:0]     d;
  } exp_t;

  exp_t              sb[$];
  exp_t              mon_e;
  int                vectors     = 0;
  int                miscompares = 0;
  int                finish_cnt  = 0;
  int                finish_cyc  = 0;
  logic [ADDR_W-1:0] last_a1     = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_word(input int r, input int w);
    logic [WORD_W-1:0] v;
    v = {r[15:0], w[15:0]};
`ifdef RAM_WR_PARITY_EN
    return {^v, v};
`else
    return v;
`endif
  endfunction

  function automatic logic [DATA_W-1:0] mk_row(input int r);
    logic [DATA_W-1:0] row;
    for (int w = 0; w < NW; w++) row[w*WORD_W +: WORD_W] = {r[15:0], w[15:0]};
    return row;
  endfunction

  // Monitor: every write pops one expectation; finish is logged with its cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus0.wr_en) begin
        if (sb.size() == 0) begin
          check("unexpected_write", 64'(bus0.wr_addr), 64'h3ff_ffff);
        end else begin
          mon_e = sb.pop_front();
          check("wr_addr", 64'(bus0.wr_addr), 64'(mon_e.a0));
          check("wr_data", 64'(bus0.wr_data), 64'(mon_e.d));
          check("wr_en_base1000", 64'(bus1.wr_en), 64'd1);
          check("wr_addr_base1000", 64'(bus1.wr_addr), 64'(mon_e.a1));
          last_a1 = bus1.wr_addr;
        end
      end
      if (finish0) begin
        finish_cnt++;
        finish_cyc = cyc;
        check("writes_pending_at_finish", 64'(sb.size()), 64'd0);
        check("busy_at_finish", 64'(busy0), 64'd1);
        check("finish_base1000", 64'(finish1), 64'd1);
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_row_ready"}, 64'(bus0.row_ready), 64'd0);
    check({tag, "_wr_en"},     64'(bus0.wr_en),     64'd0);
    check({tag, "_wr_addr"},   64'(bus0.wr_addr),   64'd0);
    check({tag, "_wr_data"},   64'(bus0.wr_data),   64'd0);
    check({tag, "_busy"},      64'(busy0),          64'd0);
    check({tag, "_finish"},    64'(finish0),        64'd0);
  endtask

  // hold: row_valid kept high; otherwise row_valid rises gap cycles after row_ready.
  task automatic run_matrix(input bit hold, input int gap, input int restart_row, input int abort_row);
    int fc0;
    int sc;
    int n;
    exp_t e;
    fc0 = finish_cnt;
    @(posedge clk); #1;
    bus0.row_valid = hold;
    bus0.row_data  = mk_row(0);
    start = 1'b1;
    sc    = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 64'(busy0), 64'd1);
    for (int r = 0; r < ROWS; r++) begin
      bus0.row_data = mk_row(r);
      n = 0;
      while (!bus0.row_ready && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      if (!bus0.row_ready) begin
        check("row_ready_timeout", 64'd0, 64'd1);
        bus0.row_valid = 1'b0;
        return;
      end
      if (!hold) begin
        repeat (gap) begin
          @(posedge clk); #1;
        end
        bus0.row_valid = 1'b1;
      end
      for (int w = 0; w < NW; w++) begin
        e.a0 = ADDR_W'(r * NW + w);
        e.a1 = ADDR_W'(1000 + r * NW + w);
        e.d  = mk_word(r, w);
        sb.push_back(e);
      end
      @(posedge clk); #1;
      if (!hold) bus0.row_valid = 1'b0;
      if (r == restart_row) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      if (r == abort_row) begin
        repeat (10) begin
          @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check_outputs_zero("abort");
        sb.delete();
        repeat (5) begin
          @(posedge clk); #1;
        end
        check("no_finish_after_abort", 64'(finish_cnt - fc0), 64'd0);
        bus0.row_valid = 1'b0;
        rst_n = 1'b1;
        return;
      end
    end
    n = 0;
    while (finish_cnt == fc0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("finish_seen", 64'(finish_cnt - fc0), 64'd1);
    if (hold) check("finish_latency", 64'(finish_cyc - sc), 64'd1057);
    check("busy_after_finish", 64'(busy0), 64'd0);
    check("finish_one_cycle", 64'(finish0), 64'd0);
    bus0.row_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("single_finish", 64'(finish_cnt - fc0), 64'd1);
    check("all_writes_done", 64'(sb.size()), 64'd0);
    check("last_addr_base1000", 64'(last_a1), 64'd999);
  endtask

  initial begin
    bus0.row_valid = 1'b0;
    bus0.row_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;

    run_matrix(1'b1, 0, -1, -1);
    run_matrix(1'b0, 5, 3, -1);
    run_matrix(1'b1, 0, -1, 10);
    run_matrix(1'b1, 0, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
